// File: rtl/r8mbe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : r8mbe_pkg
// Description : Shared types and helpers for the radix-8 modified-Booth
//               partial-product generator: digit type, multiple-select enum,
//               4-bit window recoder and size helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package r8mbe_pkg;

    // Two's-complement view of the 3-bit group {y[3i+2], y[3i+1], y[3i]}
    typedef logic signed [2:0] digit_t;

    // Which precomputed multiple of X a partial product takes
    typedef enum logic [2:0] {
        SEL_ZERO = 3'd0,
        SEL_X    = 3'd1,
        SEL_2X   = 3'd2,
        SEL_3X   = 3'd3,
        SEL_4X   = 3'd4
    } sel_e;

    // Recoded digit in sign/magnitude form
    typedef struct packed {
        sel_e sel;
        logic neg;
    } recode_t;

    function automatic int calc_num_pp(input int width);
        return width / 3 + 1;
    endfunction

    function automatic int calc_pp_w(input int width);
        return width + 3;
    endfunction

    // win = {y[3i+2], y[3i+1], y[3i], y[3i-1]}; digit = signed group + borrow bit
    function automatic recode_t booth_recode(input logic [3:0] win);
        digit_t   grp;
        logic [3:0] d;
        logic [3:0] mag;
        recode_t  r;
        grp = digit_t'(win[3:1]);
        d   = {grp[2], grp} + {3'b000, win[0]};
        mag = d[3] ? (~d + 4'd1) : d;
        r.neg = d[3];
        case (mag)
            4'd1:    r.sel = SEL_X;
            4'd2:    r.sel = SEL_2X;
            4'd3:    r.sel = SEL_3X;
            4'd4:    r.sel = SEL_4X;
            default: r.sel = SEL_ZERO;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/r8mbe_booth_sel.sv
`default_nettype none
// ============================================================================
// Module      : r8mbe_booth_sel
// Description : One partial-product selector: picks |d|*X from the four
//               precomputed multiples and one's-complements it for negative
//               digits, emitting the +1 correction bit separately.
// Revision    : 1.0 - initial release
// ============================================================================
module r8mbe_booth_sel
    import r8mbe_pkg::*;
#(
    parameter int PP_W = 14
) (
    input  logic [PP_W-1:0] i_x1,
    input  logic [PP_W-1:0] i_x2,
    input  logic [PP_W-1:0] i_x3,
    input  logic [PP_W-1:0] i_x4,
    input  sel_e            i_sel,
    input  logic            i_neg,
    output logic [PP_W-1:0] o_pp,
    output logic            o_neg
);

    logic [PP_W-1:0] w_mult;
    logic            w_neg;

    // Multiple mux, then conditional inversion; a zero digit is never negated
    always_comb begin
        w_mult = '0;
        case (i_sel)
            SEL_X:   w_mult = i_x1;
            SEL_2X:  w_mult = i_x2;
            SEL_3X:  w_mult = i_x3;
            SEL_4X:  w_mult = i_x4;
            default: w_mult = '0;
        endcase
        w_neg = i_neg && (i_sel != SEL_ZERO);
        o_pp  = w_neg ? ~w_mult : w_mult;
        o_neg = w_neg;
    end

endmodule
`default_nettype wire

// File: rtl/r8mbe_ppg_pipe.sv
`default_nettype none
// ============================================================================
// Module      : r8mbe_ppg_pipe
// Description : Two-stage elastic radix-8 Booth partial-product generator.
//               S1 registers X, 2X, 3X, 4X, the recoded digits and the tag;
//               S2 registers the selected partial products.
// Revision    : 1.0 - initial release
// ============================================================================
module r8mbe_ppg_pipe
    import r8mbe_pkg::*;
#(
    parameter  int WIDTH  = 11,
    parameter  int TAG_W  = 4,
    localparam int NUM_PP = calc_num_pp(WIDTH),
    localparam int PP_W   = calc_pp_w(WIDTH)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [WIDTH-1:0]             x_i,
    input  logic [WIDTH-1:0]             y_i,
    input  logic [TAG_W-1:0]             tag_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [NUM_PP-1:0][PP_W-1:0] pp_o,
    output logic [NUM_PP-1:0]            neg_o,
    output logic [TAG_W-1:0]             tag_o
);

    // y with the implicit y[-1]=0 below and zero padding above
    localparam int c_YE_W = 3 * NUM_PP + 1;

    logic                         w_in_ready;
    logic                         w_accept;
    logic                         w_advance;
    logic [PP_W-1:0]              w_x1;
    logic [PP_W-1:0]              w_x2;
    logic [PP_W-1:0]              w_x4;
    logic [PP_W-1:0]              w_x3;
    logic [c_YE_W-1:0]            w_y_ext;
    recode_t [NUM_PP-1:0]         w_rc;
    logic [NUM_PP-1:0][PP_W-1:0]  w_pp_sel;
    logic [NUM_PP-1:0]            w_neg_sel;

    logic                         r_s1_valid_q, w_s1_valid_d;
    logic [PP_W-1:0]              r_s1_x1_q,    w_s1_x1_d;
    logic [PP_W-1:0]              r_s1_x2_q,    w_s1_x2_d;
    logic [PP_W-1:0]              r_s1_x3_q,    w_s1_x3_d;
    logic [PP_W-1:0]              r_s1_x4_q,    w_s1_x4_d;
    recode_t [NUM_PP-1:0]         r_s1_rc_q,    w_s1_rc_d;
    logic [TAG_W-1:0]             r_s1_tag_q,   w_s1_tag_d;

    logic                         r_s2_valid_q, w_s2_valid_d;
    logic [NUM_PP-1:0][PP_W-1:0]  r_s2_pp_q,    w_s2_pp_d;
    logic [NUM_PP-1:0]            r_s2_neg_q,   w_s2_neg_d;
    logic [TAG_W-1:0]             r_s2_tag_q,   w_s2_tag_d;

    // Handshake: S1 may take new data unless both stages are stuck
    always_comb begin
        w_in_ready = !r_s1_valid_q || !r_s2_valid_q || out_ready_i;
        w_accept   = in_valid_i && w_in_ready;
        w_advance  = r_s1_valid_q && (!r_s2_valid_q || out_ready_i);
    end

    // Multiples of X; 3X is the only true addition in the datapath
    always_comb begin
        w_x1 = {3'b000, x_i};
        w_x2 = {w_x1[PP_W-2:0], 1'b0};
        w_x4 = {w_x1[PP_W-3:0], 2'b00};
        w_x3 = w_x1 + w_x2;
    end

    // Overlapping 4-bit windows of y recoded into select/negate pairs
    always_comb begin
        w_y_ext = {{(c_YE_W - WIDTH - 1){1'b0}}, y_i, 1'b0};
        for (int i = 0; i < NUM_PP; i++) begin
            w_rc[i] = booth_recode(w_y_ext[3*i +: 4]);
        end
    end

    // One selector per partial product, fed from the S1 registers
    for (genvar g = 0; g < NUM_PP; g++) begin : g_pp
        r8mbe_booth_sel #(
            .PP_W (PP_W)
        ) u_sel (
            .i_x1  (r_s1_x1_q),
            .i_x2  (r_s1_x2_q),
            .i_x3  (r_s1_x3_q),
            .i_x4  (r_s1_x4_q),
            .i_sel (r_s1_rc_q[g].sel),
            .i_neg (r_s1_rc_q[g].neg),
            .o_pp  (w_pp_sel[g]),
            .o_neg (w_neg_sel[g])
        );
    end

    // Next-state for both stages; data registers hold unless loaded
    always_comb begin
        w_s1_valid_d = r_s1_valid_q;
        w_s1_x1_d    = r_s1_x1_q;
        w_s1_x2_d    = r_s1_x2_q;
        w_s1_x3_d    = r_s1_x3_q;
        w_s1_x4_d    = r_s1_x4_q;
        w_s1_rc_d    = r_s1_rc_q;
        w_s1_tag_d   = r_s1_tag_q;
        w_s2_valid_d = r_s2_valid_q;
        w_s2_pp_d    = r_s2_pp_q;
        w_s2_neg_d   = r_s2_neg_q;
        w_s2_tag_d   = r_s2_tag_q;

        if (w_accept) begin
            w_s1_valid_d = 1'b1;
            w_s1_x1_d    = w_x1;
            w_s1_x2_d    = w_x2;
            w_s1_x3_d    = w_x3;
            w_s1_x4_d    = w_x4;
            w_s1_rc_d    = w_rc;
            w_s1_tag_d   = tag_i;
        end else if (w_advance) begin
            w_s1_valid_d = 1'b0;
        end

        if (w_advance) begin
            w_s2_valid_d = 1'b1;
            w_s2_pp_d    = w_pp_sel;
            w_s2_neg_d   = w_neg_sel;
            w_s2_tag_d   = r_s1_tag_q;
        end else if (out_ready_i) begin
            w_s2_valid_d = 1'b0;
        end
    end

    // Pipeline registers; reset drops in-flight work and clears outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_s1_valid_q <= 1'b0;
            r_s1_x1_q    <= '0;
            r_s1_x2_q    <= '0;
            r_s1_x3_q    <= '0;
            r_s1_x4_q    <= '0;
            r_s1_rc_q    <= '0;
            r_s1_tag_q   <= '0;
            r_s2_valid_q <= 1'b0;
            r_s2_pp_q    <= '0;
            r_s2_neg_q   <= '0;
            r_s2_tag_q   <= '0;
        end else begin
            r_s1_valid_q <= w_s1_valid_d;
            r_s1_x1_q    <= w_s1_x1_d;
            r_s1_x2_q    <= w_s1_x2_d;
            r_s1_x3_q    <= w_s1_x3_d;
            r_s1_x4_q    <= w_s1_x4_d;
            r_s1_rc_q    <= w_s1_rc_d;
            r_s1_tag_q   <= w_s1_tag_d;
            r_s2_valid_q <= w_s2_valid_d;
            r_s2_pp_q    <= w_s2_pp_d;
            r_s2_neg_q   <= w_s2_neg_d;
            r_s2_tag_q   <= w_s2_tag_d;
        end
    end

    assign in_ready_o  = w_in_ready;
    assign out_valid_o = r_s2_valid_q;
    assign pp_o        = r_s2_pp_q;
    assign neg_o       = r_s2_neg_q;
    assign tag_o       = r_s2_tag_q;

endmodule
`default_nettype wire

// File: tb/tb_r8mbe_ppg_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_r8mbe_ppg_pipe
// Description : Self-checking bench for r8mbe_ppg_pipe. A WIDTH=11 and a
//               WIDTH=24 instance; expected products and tags are queued on
//               accept and compared against the weighted PP sum on output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_r8mbe_ppg_pipe;

    localparam int WA  = 11;
    localparam int WB  = 24;
    localparam int TW  = 4;
    localparam int NPA = WA / 3 + 1;
    localparam int PWA = WA + 3;
    localparam int NPB = WB / 3 + 1;
    localparam int PWB = WB + 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic                       a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [WA-1:0]              a_x, a_y;
    logic [TW-1:0]              a_tag, a_tag_o;
    logic [NPA-1:0][PWA-1:0]    a_pp;
    logic [NPA-1:0]             a_neg;

    logic                       b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [WB-1:0]              b_x, b_y;
    logic [TW-1:0]              b_tag, b_tag_o;
    logic [NPB-1:0][PWB-1:0]    b_pp;
    logic [NPB-1:0]             b_neg;

    int n_cmp = 0;
    int n_bad = 0;

    longint qa_p[$];
    logic [TW-1:0] qa_t[$];
    longint qb_p[$];
    logic [TW-1:0] qb_t[$];

    r8mbe_ppg_pipe #(.WIDTH(WA), .TAG_W(TW)) u_dut_a (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(a_in_valid), .in_ready_o(a_in_ready),
        .x_i(a_x), .y_i(a_y), .tag_i(a_tag),
        .out_valid_o(a_out_valid), .out_ready_i(a_out_ready),
        .pp_o(a_pp), .neg_o(a_neg), .tag_o(a_tag_o)
    );

    r8mbe_ppg_pipe #(.WIDTH(WB), .TAG_W(TW)) u_dut_b (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(b_in_valid), .in_ready_o(b_in_ready),
        .x_i(b_x), .y_i(b_y), .tag_i(b_tag),
        .out_valid_o(b_out_valid), .out_ready_i(b_out_ready),
        .pp_o(b_pp), .neg_o(b_neg), .tag_o(b_tag_o)
    );

    // Weighted sum of sign-extended PPs plus correction bits
    function automatic longint sum_a();
        longint s = 0;
        for (int i = 0; i < NPA; i++)
            s += (longint'($signed(a_pp[i])) + longint'(a_neg[i])) * (longint'(1) << (3 * i));
        return s;
    endfunction

    function automatic longint sum_b();
        longint s = 0;
        for (int i = 0; i < NPB; i++)
            s += (longint'($signed(b_pp[i])) + longint'(b_neg[i])) * (longint'(1) << (3 * i));
        return s;
    endfunction

    // Operand picker biased towards zero and all-ones
    function automatic logic [31:0] pick_op(input int w);
        logic [31:0] m;
        int          k;
        m = (32'd1 << w) - 32'd1;
        k = int'($urandom_range(0, 7));
        if (k == 0) return 32'd0;
        if (k == 1) return m;
        return $urandom & m;
    endfunction

    // Scoreboard for instance A: pop/compare on output transfer, push on accept
    longint sa_got, sa_exp;
    logic [TW-1:0] sa_tag;
    always @(negedge clk) begin
        if (!rst) begin
            if (a_out_valid && a_out_ready) begin
                n_cmp++;
                if (qa_p.size() == 0) begin
                    n_bad++;
                    $display("FAIL sb_a_extra: got output tag %0d, required no output", a_tag_o);
                end else begin
                    sa_exp = qa_p.pop_front();
                    sa_tag = qa_t.pop_front();
                    sa_got = sum_a();
                    if (sa_got !== sa_exp || a_tag_o !== sa_tag) begin
                        n_bad++;
                        $display("FAIL sb_a_sum: got sum %0d tag %0d, required sum %0d tag %0d",
                                 sa_got, a_tag_o, sa_exp, sa_tag);
                    end
                end
            end
            if (a_in_valid && a_in_ready) begin
                qa_p.push_back(longint'(a_x) * longint'(a_y));
                qa_t.push_back(a_tag);
            end
        end
    end

    longint sb_got, sb_exp;
    logic [TW-1:0] sb_tag;
    always @(negedge clk) begin
        if (!rst) begin
            if (b_out_valid && b_out_ready) begin
                n_cmp++;
                if (qb_p.size() == 0) begin
                    n_bad++;
                    $display("FAIL sb_b_extra: got output tag %0d, required no output", b_tag_o);
                end else begin
                    sb_exp = qb_p.pop_front();
                    sb_tag = qb_t.pop_front();
                    sb_got = sum_b();
                    if (sb_got !== sb_exp || b_tag_o !== sb_tag) begin
                        n_bad++;
                        $display("FAIL sb_b_sum: got sum %0d tag %0d, required sum %0d tag %0d",
                                 sb_got, b_tag_o, sb_exp, sb_tag);
                    end
                end
            end
            if (b_in_valid && b_in_ready) begin
                qb_p.push_back(longint'(b_x) * longint'(b_y));
                qb_t.push_back(b_tag);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operation on A and return one cycle after it is accepted
    task automatic send_a(input logic [WA-1:0] x, input logic [WA-1:0] y, input logic [TW-1:0] t);
        logic acc;
        acc = 1'b0;
        a_x = x; a_y = y; a_tag = t; a_in_valid = 1'b1;
        for (int k = 0; k < 64 && !acc; k++) begin
            @(negedge clk);
            acc = a_in_ready;
            @(posedge clk);
            #1;
        end
        a_in_valid = 1'b0;
        if (!acc) begin
            n_cmp++; n_bad++;
            $display("FAIL send_a_timeout: got in_ready=0 for 64 cycles, required accept");
        end
    endtask

    task automatic drain_a(input string name);
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        for (int k = 0; k < 64 && qa_p.size() != 0; k++) tick();
        tick();
        n_cmp++;
        if (qa_p.size() != 0 || a_out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_drain: got %0d outstanding out_valid=%b, required 0 and 0",
                     name, qa_p.size(), a_out_valid);
        end
    endtask

    task automatic test_reset();
        int seen;
        rst = 1'b1;
        a_in_valid = 1'b1; a_x = 11'd7; a_y = 11'd7; a_tag = 4'd9; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_x = '0; b_y = '0; b_tag = '0; b_out_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        a_in_valid = 1'b0;
        n_cmp++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_handshake: got out_valid=%b in_ready=%b, required 0 1", a_out_valid, a_in_ready);
        end
        n_cmp++;
        if (a_pp !== '0 || a_neg !== '0 || a_tag_o !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got pp=%h neg=%b tag=%h, required all 0", a_pp, a_neg, a_tag_o);
        end
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (a_out_valid) seen++;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (seen != 0) begin
            n_bad++;
            $display("FAIL idle_no_output: got %0d valid cycles, required 0", seen);
        end
    endtask

    task automatic test_latency_5x3();
        a_out_ready = 1'b1;
        send_a(11'd5, 11'd3, 4'd1);
        n_cmp++;
        if (a_out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL lat_cycle1: got out_valid=%b, required 0", a_out_valid);
        end
        tick();
        n_cmp++;
        if (a_out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL lat_cycle2: got out_valid=%b, required 1", a_out_valid);
        end
        n_cmp++;
        if (a_pp[0] !== 14'd15 || a_neg[0] !== 1'b0 || a_tag_o !== 4'd1) begin
            n_bad++;
            $display("FAIL pp0_5x3: got pp0=%0d neg0=%b tag=%0d, required 15 0 1", a_pp[0], a_neg[0], a_tag_o);
        end
        for (int i = 1; i < NPA; i++) begin
            n_cmp++;
            if (a_pp[i] !== 14'd0 || a_neg[i] !== 1'b0) begin
                n_bad++;
                $display("FAIL ppi_5x3: index %0d got pp=%0d neg=%b, required 0 0", i, a_pp[i], a_neg[i]);
            end
        end
        tick();
    endtask

    task automatic test_negative_5x7();
        a_out_ready = 1'b1;
        send_a(11'd5, 11'd7, 4'd2);
        tick();
        n_cmp++;
        if (a_out_valid !== 1'b1 || a_pp[0] !== 14'h3FFA || a_neg[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL neg_digit0: got valid=%b pp0=%h neg0=%b, required 1 3ffa 1", a_out_valid, a_pp[0], a_neg[0]);
        end
        n_cmp++;
        if (a_pp[1] !== 14'd5 || a_neg[1] !== 1'b0 || a_pp[2] !== 14'd0 || a_pp[3] !== 14'd0) begin
            n_bad++;
            $display("FAIL pos_digit1: got pp1=%0d neg1=%b pp2=%0d pp3=%0d, required 5 0 0 0",
                     a_pp[1], a_neg[1], a_pp[2], a_pp[3]);
        end
        n_cmp++;
        if (sum_a() !== 64'sd35) begin
            n_bad++;
            $display("FAIL wsum_5x7: got %0d, required 35", sum_a());
        end
        tick();
    endtask

    task automatic test_extremes();
        a_out_ready = 1'b1;
        send_a(11'd2047, 11'd2047, 4'd3);
        tick();
        n_cmp++;
        if (a_out_valid !== 1'b1 || sum_a() !== 64'sd4190209) begin
            n_bad++;
            $display("FAIL wsum_max: got valid=%b sum=%0d, required 1 4190209", a_out_valid, sum_a());
        end
        tick();
        send_a(11'd0, 11'd0, 4'd4);
        tick();
        n_cmp++;
        if (a_out_valid !== 1'b1 || sum_a() !== 64'sd0 || a_pp !== '0 || a_neg !== '0) begin
            n_bad++;
            $display("FAIL wsum_zero: got valid=%b sum=%0d neg=%b, required 1 0 0", a_out_valid, sum_a(), a_neg);
        end
        tick();
    endtask

    task automatic test_backpressure();
        int idx;
        logic [NPA-1:0][PWA-1:0] held_pp;
        logic [NPA-1:0]          held_neg;
        logic [TW-1:0]           held_tag;
        idx = 0;
        held_pp = '0; held_neg = '0; held_tag = '0;
        a_out_ready = 1'b0;
        for (int c = 0; c < 40 && idx < 6; c++) begin
            if (c == 4) a_out_ready = 1'b1;
            a_in_valid = 1'b1;
            a_x = WA'(pick_op(WA));
            a_y = WA'(pick_op(WA));
            a_tag = TW'(idx + 8);
            @(negedge clk);
            if (c == 2) begin
                n_cmp++;
                if (a_in_ready !== 1'b0 || idx != 2 || a_out_valid !== 1'b1 || a_tag_o !== 4'd8) begin
                    n_bad++;
                    $display("FAIL bp_stall: got in_ready=%b accepts=%0d valid=%b tag=%0d, required 0 2 1 8",
                             a_in_ready, idx, a_out_valid, a_tag_o);
                end
                held_pp = a_pp; held_neg = a_neg; held_tag = a_tag_o;
            end
            if (c == 3) begin
                n_cmp++;
                if (a_in_ready !== 1'b0 || a_pp !== held_pp || a_neg !== held_neg || a_tag_o !== held_tag) begin
                    n_bad++;
                    $display("FAIL bp_hold: got in_ready=%b pp=%h tag=%0d, required 0 pp=%h tag=%0d",
                             a_in_ready, a_pp, a_tag_o, held_pp, held_tag);
                end
            end
            if (a_in_ready) idx++;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (idx != 6) begin
            n_bad++;
            $display("FAIL bp_accepts: got %0d, required 6", idx);
        end
        drain_a("bp");
    endtask

    task automatic test_back_to_back();
        int stalls, outs;
        stalls = 0; outs = 0;
        a_out_ready = 1'b1;
        for (int c = 0; c < 24; c++) begin
            a_in_valid = 1'b1;
            a_x = WA'(pick_op(WA));
            a_y = WA'(pick_op(WA));
            a_tag = TW'(c);
            @(negedge clk);
            if (!a_in_ready) stalls++;
            if (a_out_valid) outs++;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (stalls != 0 || outs != 22) begin
            n_bad++;
            $display("FAIL b2b_rate: got stalls=%0d outputs=%0d, required 0 22", stalls, outs);
        end
        drain_a("b2b");
    endtask

    task automatic test_reset_midflight();
        int cnt;
        cnt = 0;
        a_out_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            a_in_valid = 1'b1;
            a_x = WA'(pick_op(WA)); a_y = WA'(pick_op(WA)); a_tag = TW'(c + 12);
            @(negedge clk);
            if (a_in_ready) cnt++;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (cnt != 2 || a_out_valid !== 1'b1 || a_in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_full: got accepts=%0d valid=%b in_ready=%b, required 2 1 0", cnt, a_out_valid, a_in_ready);
        end
        rst = 1'b1;
        a_x = 11'd3; a_y = 11'd3; a_tag = 4'd15;
        tick();
        rst = 1'b0;
        a_in_valid = 1'b0;
        qa_p.delete();
        qa_t.delete();
        n_cmp++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_pp !== '0 || a_neg !== '0 || a_tag_o !== '0) begin
            n_bad++;
            $display("FAIL rst_flush: got valid=%b in_ready=%b pp=%h tag=%0d, required 0 1 0 0",
                     a_out_valid, a_in_ready, a_pp, a_tag_o);
        end
        a_out_ready = 1'b1;
        send_a(11'd9, 11'd13, 4'd6);
        n_cmp++;
        if (a_out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_after_c1: got out_valid=%b, required 0", a_out_valid);
        end
        tick();
        n_cmp++;
        if (a_out_valid !== 1'b1 || a_tag_o !== 4'd6 || sum_a() !== 64'sd117) begin
            n_bad++;
            $display("FAIL rst_after_c2: got valid=%b tag=%0d sum=%0d, required 1 6 117", a_out_valid, a_tag_o, sum_a());
        end
        drain_a("rst");
    endtask

    task automatic test_random_a(input int n);
        int acc;
        acc = 0;
        for (int c = 0; c < 40000 && acc < n; c++) begin
            a_in_valid  = ($urandom_range(0, 3) != 0);
            a_out_ready = ($urandom_range(0, 3) != 0);
            a_x = WA'(pick_op(WA)); a_y = WA'(pick_op(WA)); a_tag = TW'($urandom);
            @(negedge clk);
            if (a_in_valid && a_in_ready) acc++;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (acc != n) begin
            n_bad++;
            $display("FAIL rand_a_count: got %0d accepts, required %0d", acc, n);
        end
        drain_a("rand_a");
    endtask

    task automatic test_random_b(input int n);
        int acc;
        acc = 0;
        for (int c = 0; c < 10000 && acc < n; c++) begin
            b_in_valid  = ($urandom_range(0, 3) != 0);
            b_out_ready = ($urandom_range(0, 3) != 0);
            b_x = WB'(pick_op(WB)); b_y = WB'(pick_op(WB)); b_tag = TW'($urandom);
            @(negedge clk);
            if (b_in_valid && b_in_ready) acc++;
            @(posedge clk); #1;
        end
        b_in_valid  = 1'b0;
        b_out_ready = 1'b1;
        for (int k = 0; k < 64 && qb_p.size() != 0; k++) tick();
        tick();
        n_cmp++;
        if (acc != n || qb_p.size() != 0 || b_out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rand_b: got accepts=%0d outstanding=%0d valid=%b, required %0d 0 0",
                     acc, qb_p.size(), b_out_valid, n);
        end
    endtask

    initial begin
        rst = 1'b1;
        a_in_valid = 1'b0; a_out_ready = 1'b1; a_x = '0; a_y = '0; a_tag = '0;
        b_in_valid = 1'b0; b_out_ready = 1'b1; b_x = '0; b_y = '0; b_tag = '0;
        test_reset();
        test_latency_5x3();
        test_negative_5x7();
        test_extremes();
        test_backpressure();
        test_back_to_back();
        test_reset_midflight();
        test_random_a(10000);
        test_random_b(2000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/r8mbe_ppg_pipe.md
R8MBE_PPG_PIPE -- requirements
Module: r8mbe_ppg_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 11: unsigned multiplicand/multiplier width, minimum 4.
REQ-002 SHALL have parameter TAG_W, default 4: width of the sideband tag carried with each operation.
REQ-003 SHALL have derived localparams NUM_PP = WIDTH/3 + 1 (partial-product count) and PP_W = WIDTH + 3 (partial-product width).
REQ-004 SHALL have port clk_i, input, 1: single clock, all state updates on the rising edge.
REQ-005 SHALL have port rst_i, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port in_valid_i, input, 1: operand pair valid.
REQ-007 SHALL have port in_ready_o, output, 1: block accepts the operand pair this cycle.
REQ-008 SHALL have port x_i, input, WIDTH: multiplicand.
REQ-009 SHALL have port y_i, input, WIDTH: multiplier, which is Booth-recoded.
REQ-010 SHALL have port tag_i, input, TAG_W: sideband tag.
REQ-011 SHALL have port out_valid_o, output, 1: partial-product set valid.
REQ-012 SHALL have port out_ready_i, input, 1: downstream consumes the set.
REQ-013 SHALL have port pp_o, output, NUM_PP x PP_W: partial products, with index i weighted by 8^i.
REQ-014 SHALL have port neg_o, output, NUM_PP: per-PP +1 correction bits for negated multiples.
REQ-015 SHALL have port tag_o, output, TAG_W: tag aligned with pp_o.

Function
REQ-016 SHALL transfer an input when in_valid_i && in_ready_o, and an output when out_valid_o && out_ready_i.
REQ-017 SHALL be a two-stage elastic pipeline, S1 then S2, with 2-cycle latency from input accept to out_valid_o and throughput of one set per cycle with no bubbles while out_ready_i=1.
REQ-018 SHALL capture in S1: X zero-extended to PP_W bits, 2X, 4X, 3X = X + 2X from one PP_W-bit adder, tag, and the NUM_PP Booth digits.
REQ-019 SHALL form Booth digit i from bits (y[3i+2], y[3i+1], y[3i], y[3i-1]), with y[-1]=0 and bits >= WIDTH equal to 0, as d = -4*y[3i+2] + 2*y[3i+1] + y[3i] + y[3i-1], range -4..+4.
REQ-020 SHALL select in S2 the multiple M=|d|*X per PP; d>0 -> pp_o[i]=M, neg_o[i]=0; d<0 -> pp_o[i]=~M, neg_o[i]=1; d=0 (including pattern 1111) -> pp_o[i]=0, neg_o[i]=0.
REQ-021 SHALL guarantee, as its arithmetic invariant, that the sum over i of (sign-extended pp_o[i] + neg_o[i]) * 8^i equals x_i*y_i exactly, over the full unsigned range.
REQ-022 SHALL compute in_ready_o = !s1_valid || !s2_valid || out_ready_i, combinational with no dependence on in_valid_i.
REQ-023 SHALL advance S1 to S2 when S2 is empty or S2 is being consumed in the same cycle.
REQ-024 SHALL hold pp_o, neg_o and tag_o stable while out_valid_o=1 && out_ready_i=0.
REQ-025 SHALL handle a simultaneous accept, S1-to-S2 advance and output consume in one cycle with no loss or duplication.
REQ-026 SHALL deliver outputs in acceptance order.
REQ-027 SHALL NOT accept any input while in_valid_i=0, with no state change in that case.

Reset
REQ-028 SHALL, on rst_i=1 at a clock edge, clear both stage valids, so out_valid_o=0 and in_ready_o=1 in the following cycle.
REQ-029 SHALL reset pp_o, neg_o and tag_o to 0.
REQ-030 SHALL discard in-flight operations on reset mid-operation, including a set held under backpressure, with no output produced for them.
REQ-031 SHALL ignore in_valid_i during a cycle in which rst_i=1.

Structure
REQ-032 SHALL place in package r8mbe_pkg: the 3-bit signed digit typedef, a multiple-select enum (SEL_ZERO, SEL_X, SEL_2X, SEL_3X, SEL_4X), a recode function from 4 bits to (select, negate), and the NUM_PP/PP_W helper functions.
REQ-033 SHALL instantiate NUM_PP copies, via generate, of sub-module r8mbe_booth_sel: one PP selector taking the four multiples, select and negate, and producing pp and neg.
REQ-034 SHALL contain no multiplier operator, with 3X produced only by the S1 adder.

Verification
REQ-035 SHALL cover, with WIDTH=11: x=5, y=3 -> pp_o[0]=15, neg_o[0]=0, all other PPs 0; out_valid_o exactly 2 cycles after accept.
REQ-036 SHALL cover: x=5, y=7 -> digit0=-1: pp_o[0]=~5 (PP_W bits), neg_o[0]=1; digit1=+1: pp_o[1]=5; weighted sum = 35.
REQ-037 SHALL cover: x=2047, y=2047, then x=0 and y=0 -> weighted sums 4190209 and 0; the invariant also checked on 10k random pairs plus WIDTH=24 (NUM_PP=9).
REQ-038 SHALL cover: stream 6 tagged inputs with out_ready_i=0 for 4 cycles -> in_ready_o=0 after 2 accepts; outputs held stable; all 6 tags emerge in order after release, no loss.
REQ-039 SHALL cover: continuous in_valid_i=1 and out_ready_i=1 -> one output per cycle, in_ready_o never 0.
REQ-040 SHALL cover: assert rst_i for 1 cycle with both stages full and out_ready_i=0 -> next cycle out_valid_o=0, pp_o=0, in_ready_o=1; a subsequent input is produced 2 cycles later.
